// File: rtl/grf_scoreboard.sv
// General register file with two bypassed combinational read ports, one
// synchronous write port and a per-register pending-write scoreboard that
// decode consults to stall on registers whose producer has not written back.
module grf_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              stall1,
    output logic              stall2,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ok,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [31:0]       wpc
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] gpr  [DEPTH];
    logic [CNT_W-1:0]  pend [DEPTH];
    logic              inc;
    logic              dec;

    // wpc only feeds the simulation write trace, which lives outside the design
    logic unused_trace_pc;
    assign unused_trace_pc = ^wpc;

    // Register 0 reads as zero; a same-cycle write-back is forwarded.
    function automatic logic [DATA_W-1:0] bypass_read(
        input logic [ADDR_W-1:0] ra,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] stored
    );
        if (ra == '0)
            return '0;
        else if (wr_en && wr_addr == ra)
            return wr_data;
        else
            return stored;
    endfunction

    // Stall while writes are outstanding, unless the only one is landing now.
    function automatic logic hazard(
        input logic [ADDR_W-1:0] ra,
        input logic [CNT_W-1:0]  cnt,
        input logic              wr_en,
        input logic [ADDR_W-1:0] wr_addr
    );
        return (ra != '0) && (cnt != '0) &&
               !(wr_en && wr_addr == ra && cnt == CNT_W'(1));
    endfunction

    // Counter step; simultaneous issue and write-back cancel out.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cnt,
        input logic             up,
        input logic             down
    );
        if (up && !down)
            return cnt + CNT_W'(1);
        else if (down && !up)
            return cnt - CNT_W'(1);
        else
            return cnt;
    endfunction

    assign rd1    = bypass_read(ra1, we, wa, wd, gpr[ra1]);
    assign rd2    = bypass_read(ra2, we, wa, wd, gpr[ra2]);
    assign stall1 = hazard(ra1, pend[ra1], we, wa);
    assign stall2 = hazard(ra2, pend[ra2], we, wa);

    // Issue is accepted unless the destination counter is saturated.
    assign iss_ok = (iss_addr == '0) || (pend[iss_addr] != CNT_MAX);
    assign inc    = iss_en && iss_ok && (iss_addr != '0);
    // Write-backs to an idle register update data but never underflow the count.
    assign dec    = we && (wa != '0) && (pend[wa] != '0);

    // Register array: reset clears every entry, writes to $0 are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                gpr[i] <= '0;
        end else if (we && wa != '0) begin
            gpr[wa] <= wd;
        end
    end

    // Pending-write counters; entry 0 is only ever cleared, so it stays zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                pend[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++)
                pend[i] <= next_count(pend[i],
                                      inc && (iss_addr == ADDR_W'(i)),
                                      dec && (wa == ADDR_W'(i)));
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Randomised scoreboard bench for grf_scoreboard: a driver applies one
// instruction-slot of stimulus per cycle, predicts the combinational outputs
// from a plain array model and queues them; a monitor compares on negedge.
module tb_grf_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 2;
    localparam int NREG   = 32;
    localparam int MAXPEND = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] ra1, ra2, iss_addr, wa;
    logic [DATA_W-1:0] rd1, rd2, wd;
    logic              stall1, stall2, iss_en, iss_ok, we;
    logic [31:0]       wpc;

    grf_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .stall1(stall1), .stall2(stall2),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(iss_ok),
        .we(we), .wa(wa), .wd(wd), .wpc(wpc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        reset;
        logic [4:0]  ra1, ra2;
        logic        iss_en;
        logic [4:0]  iss_addr;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd, wpc;
    } stim_t;

    typedef struct {
        logic [4:0]  ra1, ra2, iss_addr;
        logic [31:0] rd1, rd2;
        logic        stall1, stall2, iss_ok;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_gpr [NREG];
    int          m_pend[NREG];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic stim_t idle();
        stim_t s;
        s.reset = 0; s.ra1 = 0; s.ra2 = 0; s.iss_en = 0; s.iss_addr = 0;
        s.we = 0; s.wa = 0; s.wd = 0; s.wpc = 32'h0000_1000;
        return s;
    endfunction

    task automatic check(input string name, input int addr,
                         input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (addr %0d) at %0t: got %h, expected %h",
                     name, addr, $time, act, exp);
        end
    endtask

    // Predict outputs from the architectural state, then advance that state.
    task automatic apply(input stim_t s);
        exp_t e;
        int   ra;
        reset = s.reset; ra1 = s.ra1; ra2 = s.ra2;
        iss_en = s.iss_en; iss_addr = s.iss_addr;
        we = s.we; wa = s.wa; wd = s.wd; wpc = s.wpc;

        e.ra1 = s.ra1; e.ra2 = s.ra2; e.iss_addr = s.iss_addr;
        for (int p = 0; p < 2; p++) begin
            logic [31:0] val;
            logic        stl;
            ra = (p == 0) ? int'(s.ra1) : int'(s.ra2);
            if (ra == 0) val = 0;
            else if (s.we && int'(s.wa) == ra) val = s.wd;
            else val = m_gpr[ra];
            stl = (ra != 0) && (m_pend[ra] > 0) &&
                  !(s.we && int'(s.wa) == ra && m_pend[ra] == 1);
            if (p == 0) begin e.rd1 = val; e.stall1 = stl; end
            else        begin e.rd2 = val; e.stall2 = stl; end
        end
        e.iss_ok = (s.iss_addr == 0) || (m_pend[s.iss_addr] < MAXPEND);
        q.push_back(e);

        if (s.reset) begin
            for (int i = 0; i < NREG; i++) begin m_gpr[i] = 0; m_pend[i] = 0; end
        end else begin
            int pend_wa;
            pend_wa = m_pend[s.wa];
            if (s.we && s.wa != 0) m_gpr[s.wa] = s.wd;
            if (s.iss_en && e.iss_ok && s.iss_addr != 0)
                m_pend[s.iss_addr] = m_pend[s.iss_addr] + 1;
            if (s.we && s.wa != 0 && pend_wa > 0)
                m_pend[s.wa] = m_pend[s.wa] - 1;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: trace write-backs and compare whenever a prediction is queued.
    always @(negedge clk) begin
        if (we === 1'b1)
            $display("@%h: $%0d <= %h", wpc, wa, wd);
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("rd1", int'(e.ra1), rd1, e.rd1);
            check("rd2", int'(e.ra2), rd2, e.rd2);
            check("stall1", int'(e.ra1), {31'b0, stall1}, {31'b0, e.stall1});
            check("stall2", int'(e.ra2), {31'b0, stall2}, {31'b0, e.stall2});
            check("iss_ok", int'(e.iss_addr), {31'b0, iss_ok}, {31'b0, e.iss_ok});
        end
    end

    initial begin
        stim_t s;
        for (int i = 0; i < NREG; i++) begin m_gpr[i] = 0; m_pend[i] = 0; end
        s = idle();
        reset = 1; ra1 = 0; ra2 = 0; iss_en = 0; iss_addr = 0;
        we = 0; wa = 0; wd = 0; wpc = 0;
        repeat (2) @(posedge clk);
        #1;

        // Write to $5 colliding with reset, then confirm it was dropped
        s = idle(); s.reset = 1; s.we = 1; s.wa = 5; s.wd = 32'h1234_5678; s.ra1 = 5;
        apply(s);
        s = idle(); s.ra1 = 5; s.ra2 = 5;
        apply(s);

        // Sweep every address straight out of reset
        for (int i = 0; i < NREG; i++) begin
            s = idle(); s.ra1 = 5'(i); s.ra2 = 5'(NREG - 1 - i); s.iss_addr = 5'(i);
            apply(s);
        end

        // Write to $0 is discarded
        s = idle(); s.we = 1; s.wa = 0; s.wd = 32'hFFFF_FFFF; s.ra1 = 0;
        apply(s);
        s = idle(); s.ra1 = 0;
        apply(s);

        // Single producer on $8, bypassed on its write-back
        s = idle(); s.iss_en = 1; s.iss_addr = 8;
        apply(s);
        s = idle(); s.ra1 = 8;
        apply(s);
        s = idle(); s.ra1 = 8; s.we = 1; s.wa = 8; s.wd = 32'hDEAD_BEEF;
        apply(s);
        s = idle(); s.ra1 = 8; s.ra2 = 8; s.iss_addr = 8;
        apply(s);

        // Saturate $9 and drain it
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.iss_en = 1; s.iss_addr = 9; s.ra1 = 9;
            apply(s);
        end
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.we = 1; s.wa = 9; s.wd = 32'h9000_0000 + i; s.ra1 = 9;
            s.iss_addr = 9;
            apply(s);
            s = idle(); s.ra1 = 9; s.ra2 = 9; s.iss_addr = 9;
            apply(s);
        end

        // Issue and write-back on $10 in the same cycle
        s = idle(); s.iss_en = 1; s.iss_addr = 10;
        apply(s);
        s = idle(); s.iss_en = 1; s.iss_addr = 10; s.we = 1; s.wa = 10;
        s.wd = 32'hA0A0_0010; s.ra1 = 10;
        apply(s);
        s = idle(); s.ra1 = 10; s.iss_addr = 10;
        apply(s);

        // Write-back to idle $11
        s = idle(); s.we = 1; s.wa = 11; s.wd = $urandom;
        apply(s);
        s = idle(); s.ra2 = 11; s.iss_addr = 11;
        apply(s);

        // Random traffic, addresses mostly clustered to build up hazards
        for (int n = 0; n < 1500; n++) begin
            s = idle();
            s.reset    = ($urandom_range(0, 199) == 0);
            s.ra1      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            s.ra2      = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            s.iss_en   = ($urandom_range(0, 1) == 1);
            s.iss_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            s.we       = ($urandom_range(0, 2) != 0);
            s.wa       = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            s.wd       = $urandom;
            s.wpc      = 32'h0000_2000 + 32'(n * 4);
            apply(s);
        end

        s = idle();
        reset = s.reset; ra1 = s.ra1; ra2 = s.ra2; iss_en = 0; we = 0;
        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Parametrised general register file for the pipelined CPU; replaces the single-cycle GPR array.
- Provides two combinational read ports with same-cycle write-through bypass and one synchronous write port.
- Adds a per-register pending-write scoreboard. Decode uses it to stall on registers whose producer has not yet written back.
- Register 0 is hardwired to zero and is never tracked.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- CNT_W, 2, width of each pending-write counter; max in-flight writes per register = 2**CNT_W-1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- ra1  in  ADDR_W  read address, port 1 (rs)
- ra2  in  ADDR_W  read address, port 2 (rt)
- rd1  out  DATA_W  read data, port 1
- rd2  out  DATA_W  read data, port 2
- stall1  out  1  ra1 has an outstanding write not satisfied this cycle
- stall2  out  1  same, for ra2
- iss_en  in  1  decode issues an instruction that will write iss_addr
- iss_addr  in  ADDR_W  destination register of the issued instruction
- iss_ok  out  1  issue slot accepted (counter for iss_addr not saturated)
- we  in  1  write-back enable
- wa  in  ADDR_W  write-back address
- wd  in  DATA_W  write-back data
- wpc  in  32  PC of the writing instruction (trace only)

Behaviour:
- Reset: reset=1 at a posedge clears all registers and all pending counters to 0. This applies mid-operation and overrides a same-cycle we or iss_en. Outputs are combinational, so after reset rd1/rd2=0, stall1/stall2=0, iss_ok=1.
- Read path (combinational, 0 latency):
  - rdN = 0 if raN==0.
  - Otherwise rdN = wd if we && wa==raN.
  - Otherwise rdN = GPR[raN].
- Write path:
  - At posedge with we && wa!=0 && !reset, GPR[wa] <= wd.
  - Writes to address 0 are discarded.
  - Simulation only: every cycle with we=1 prints "@<wpc hex>: $<wa dec> <= <wd hex>", including wa==0.
- Pending counters pend[i], CNT_W bits each; pend[0] is always 0.
  - inc = iss_en && iss_ok && iss_addr!=0.
  - dec = we && wa!=0 && pend[wa]!=0.
  - Same register with inc and dec in the same cycle: count unchanged.
  - Only inc: +1. Only dec: -1.
  - A write-back to a register whose count is 0 writes data and leaves the count at 0; no underflow.
- iss_ok = 1 if iss_addr==0, or if pend[iss_addr] < 2**CNT_W-1.
  - If iss_ok=0 the issue is ignored and decode must hold.
  - Saturation does not block writes, reads or decrements.
  - A same-cycle dec on iss_addr does not raise iss_ok; the check uses the registered count.
- stallN = raN!=0 && pend[raN]!=0 && !(we && wa==raN && pend[raN]==1).
  - The last outstanding write arriving this cycle is bypassed, so no stall.
  - An older write arriving while a younger one is pending still stalls.
- Issue from the same instruction does not affect its own stall this cycle: stallN uses the pre-update count.
- All counter and register updates occur only at posedge clk. No other state exists.

Test Plan:
- Reset then read all 32 addresses -> every rd=0, stall=0, iss_ok=1. Write $5=0x1234_5678, reset in the same cycle -> $5 reads 0.
- we=1, wa=0, wd=0xFFFF_FFFF, then read ra1=0 -> rd1=0. Trace line still printed with wa=0.
- Issue $8; next cycle ra1=8 -> stall1=1. Write-back wa=8, wd=0xDEAD_BEEF with ra1=8 in the same cycle -> stall1=0, rd1=0xDEAD_BEEF. Next cycle pend[8]=0 and GPR[8]=0xDEAD_BEEF.
- Issue $9 three times (CNT_W=2) -> iss_ok=1 each time, then iss_ok=0 and the fourth issue is ignored. One write-back to $9 -> stall on ra=9 stays 1. After three write-backs -> stall=0.
- Same cycle: issue $10 and write-back $10 with pend[10]=1 -> pend[10] stays 1, stall on ra=10 next cycle =1.
- Write-back $11 with pend[11]=0 -> GPR[11] updated, pend[11] stays 0. Read ra2=11 next cycle -> rd2 = written value, stall2=0.
